// File: rtl/core_pkg.sv
// Shared types for the core pipeline control path:
// FSM state encoding and the per-cycle pipeline control bundle.
package core_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        MC_STALL   = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_hold;
    } ctrl_t;

    // Pass-through: PC and IF/ID advance, no NOP injected, EX runs.
    localparam ctrl_t CTRL_PASS = '{
        pc_write:     1'b1,
        if_id_write:  1'b1,
        if_id_flush:  1'b0,
        id_ex_bubble: 1'b0,
        ex_hold:      1'b0
    };

    function automatic ctrl_t ctrl_stall(input logic bubble,
                                         input logic hold);
        ctrl_t c;
        c              = CTRL_PASS;
        c.pc_write     = 1'b0;
        c.if_id_write  = 1'b0;
        c.id_ex_bubble = bubble;
        c.ex_hold      = hold;
        return c;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID/EX hazard information in, pipeline write/flush/hold controls out.
// master = pipeline side, slave = hazard controller.
interface hazard_stall_ctrl_if
    import core_pkg::*;
#(
    parameter int PERF_W = 32
);
    logic [REG_AW-1:0] id_AddrA;
    logic [REG_AW-1:0] id_AddrB;
    logic              id_useA;
    logic              id_useB;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_RegWrite;
    logic              ex_MemRead;
    logic              ex_mc_start;
    logic              ex_BranchTaken;
    logic              perf_clr;
    logic              PCWrite;
    logic              IF_ID_Write;
    logic              IF_ID_Flush;
    logic              ID_EX_Bubble;
    logic              EX_Hold;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_AddrA, id_AddrB, id_useA, id_useB,
        output ex_rd, ex_RegWrite, ex_MemRead,
        output ex_mc_start, ex_BranchTaken, perf_clr,
        input  PCWrite, IF_ID_Write, IF_ID_Flush,
        input  ID_EX_Bubble, EX_Hold, stall_cycles
    );

    modport slave (
        input  id_AddrA, id_AddrB, id_useA, id_useB,
        input  ex_rd, ex_RegWrite, ex_MemRead,
        input  ex_mc_start, ex_BranchTaken, perf_clr,
        output PCWrite, IF_ID_Write, IF_ID_Flush,
        output ID_EX_Bubble, EX_Hold, stall_cycles
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [PERF_W-1:0] cnt
);

    logic [PERF_W-1:0] cnt_q;
    logic [PERF_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / multi-cycle-op stall and taken-branch flush controller
// sitting between ID and EX, with a stall-cycle performance counter.
module hazard_stall_ctrl
    import core_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int MC_LAT   = 4,
    parameter int PERF_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_stall_ctrl_if.slave bus
);

    localparam int MAX_LAT = (LOAD_LAT > MC_LAT) ? LOAD_LAT : MC_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    // The detection cycle already counts as the first stall/hold cycle.
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_LAT - 2);
    localparam logic [CNT_W-1:0] MC_INIT = CNT_W'(MC_LAT - 3);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    ctrl_t             ctrl;
    logic              haz_a;
    logic              haz_b;
    logic              lu;
    logic [PERF_W-1:0] stall_cnt;

    assign haz_a = bus.id_useA & bus.ex_RegWrite & bus.ex_MemRead
                 & (bus.ex_rd == bus.id_AddrA) & (bus.id_AddrA != '0);
    assign haz_b = bus.id_useB & bus.ex_RegWrite & bus.ex_MemRead
                 & (bus.ex_rd == bus.id_AddrB) & (bus.id_AddrB != '0);
    assign lu    = haz_a | haz_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = CTRL_PASS;
        unique case (state_q)
            IDLE: begin
                if (bus.ex_BranchTaken) begin
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_ex_bubble = 1'b1;
                end else if (bus.ex_mc_start) begin
                    ctrl = ctrl_stall(1'b0, 1'b1);
                    if (MC_LAT > 2) begin
                        cnt_d   = MC_INIT;
                        state_d = MC_STALL;
                    end
                end else if (lu) begin
                    ctrl = ctrl_stall(1'b1, 1'b0);
                    if (LOAD_LAT > 1) begin
                        cnt_d   = LD_INIT;
                        state_d = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                ctrl = ctrl_stall(1'b1, 1'b0);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MC_STALL: begin
                ctrl = ctrl_stall(1'b0, 1'b1);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(
        .PERF_W (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl.pc_write),
        .clr   (bus.perf_clr),
        .cnt   (stall_cnt)
    );

    assign bus.PCWrite      = ctrl.pc_write;
    assign bus.IF_ID_Write  = ctrl.if_id_write;
    assign bus.IF_ID_Flush  = ctrl.if_id_flush;
    assign bus.ID_EX_Bubble = ctrl.id_ex_bubble;
    assign bus.EX_Hold      = ctrl.ex_hold;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: u1 has LOAD_LAT=1, u3 has LOAD_LAT=3 with a 3-bit
// counter so saturation shows up; both see the same stimulus.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_AddrA, id_AddrB, ex_rd;
    logic       id_useA, id_useB, ex_RegWrite, ex_MemRead;
    logic       ex_mc_start, ex_BranchTaken, perf_clr;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.PERF_W(32)) b1 ();
    hazard_stall_ctrl_if #(.PERF_W(3))  b3 ();

    assign b1.id_AddrA = id_AddrA;       assign b3.id_AddrA = id_AddrA;
    assign b1.id_AddrB = id_AddrB;       assign b3.id_AddrB = id_AddrB;
    assign b1.id_useA = id_useA;         assign b3.id_useA = id_useA;
    assign b1.id_useB = id_useB;         assign b3.id_useB = id_useB;
    assign b1.ex_rd = ex_rd;             assign b3.ex_rd = ex_rd;
    assign b1.ex_RegWrite = ex_RegWrite; assign b3.ex_RegWrite = ex_RegWrite;
    assign b1.ex_MemRead = ex_MemRead;   assign b3.ex_MemRead = ex_MemRead;
    assign b1.ex_mc_start = ex_mc_start; assign b3.ex_mc_start = ex_mc_start;
    assign b1.ex_BranchTaken = ex_BranchTaken;
    assign b3.ex_BranchTaken = ex_BranchTaken;
    assign b1.perf_clr = perf_clr;       assign b3.perf_clr = perf_clr;

    hazard_stall_ctrl #(
        .LOAD_LAT (1),
        .MC_LAT   (4),
        .PERF_W   (32)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    hazard_stall_ctrl #(
        .LOAD_LAT (3),
        .MC_LAT   (4),
        .PERF_W   (3)
    ) u3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3.slave)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_in();
        id_AddrA = '0; id_AddrB = '0; id_useA = 1'b0; id_useB = 1'b0;
        ex_rd = '0; ex_RegWrite = 1'b0; ex_MemRead = 1'b0;
        ex_mc_start = 1'b0; ex_BranchTaken = 1'b0;
    endtask

    task automatic load_use_a();
        idle_in();
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd5;
        id_AddrA = 5'd5; id_useA = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; perf_clr = 1'b0;
        idle_in();
        step(); #1;
        chk("rst_pcw",   b1.PCWrite, 1);
        chk("rst_ifw",   b1.IF_ID_Write, 1);
        chk("rst_flush", b1.IF_ID_Flush, 0);
        chk("rst_bub",   b1.ID_EX_Bubble, 0);
        chk("rst_hold",  b1.EX_Hold, 0);
        chk("rst_cnt",   b1.stall_cycles, 0);
        chk("rst_cnt3",  32'(b3.stall_cycles), 0);
        step(); rst_n = 1'b1;

        // Load-use on rs1
        step(); load_use_a(); #1;
        chk("lu1_pcw", b1.PCWrite, 0);
        chk("lu1_bub", b1.ID_EX_Bubble, 1);
        chk("lu1_ifw", b1.IF_ID_Write, 0);
        chk("lu3_pcw0", b3.PCWrite, 0);
        step(); idle_in(); #1;
        chk("lu1_rel_pcw", b1.PCWrite, 1);
        chk("lu1_rel_bub", b1.ID_EX_Bubble, 0);
        chk("lu1_cnt", b1.stall_cycles, 1);
        chk("lu3_pcw1", b3.PCWrite, 0);
        chk("lu3_bub1", b3.ID_EX_Bubble, 1);
        chk("lu3_cnt1", 32'(b3.stall_cycles), 1);
        step(); #1;
        chk("lu3_pcw2", b3.PCWrite, 0);
        chk("lu3_cnt2", 32'(b3.stall_cycles), 2);
        chk("lu1_cnt_hold", b1.stall_cycles, 1);
        step(); #1;
        chk("lu3_rel_pcw", b3.PCWrite, 1);
        chk("lu3_cnt3", 32'(b3.stall_cycles), 3);

        // x0 and unused operand never stall; rs2 hazard does
        step(); idle_in();
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd0;
        id_AddrB = 5'd0; id_useB = 1'b1; #1;
        chk("x0_pcw1", b1.PCWrite, 1);
        chk("x0_pcw3", b3.PCWrite, 1);
        step(); ex_rd = 5'd7; id_AddrB = 5'd7; id_useB = 1'b0; #1;
        chk("nouse_pcw1", b1.PCWrite, 1);
        chk("nouse_pcw3", b3.PCWrite, 1);
        step(); id_useB = 1'b1; #1;
        chk("hb_pcw1", b1.PCWrite, 0);
        chk("hb_bub3", b3.ID_EX_Bubble, 1);
        step(); idle_in(); #1;
        chk("hb_rel1", b1.PCWrite, 1);
        chk("hb_pcw3", b3.PCWrite, 0);
        step(); step(); #1;
        chk("hb_rel3", b3.PCWrite, 1);
        chk("hb_cnt1", b1.stall_cycles, 2);
        chk("hb_cnt3", 32'(b3.stall_cycles), 6);

        // Multi-cycle op, branch during hold ignored
        step(); ex_mc_start = 1'b1; #1;
        chk("mc0_hold", b1.EX_Hold, 1);
        chk("mc0_pcw", b1.PCWrite, 0);
        chk("mc0_bub", b1.ID_EX_Bubble, 0);
        step(); ex_mc_start = 1'b0; ex_BranchTaken = 1'b1; #1;
        chk("mc1_hold", b1.EX_Hold, 1);
        chk("mc1_flush", b1.IF_ID_Flush, 0);
        chk("mc1_pcw", b1.PCWrite, 0);
        chk("mc1_hold3", b3.EX_Hold, 1);
        step(); ex_BranchTaken = 1'b0; #1;
        chk("mc2_hold", b1.EX_Hold, 1);
        step(); #1;
        chk("mc3_hold", b1.EX_Hold, 0);
        chk("mc3_pcw", b1.PCWrite, 1);
        chk("mc3_hold3", b3.EX_Hold, 0);
        chk("mc_cnt1", b1.stall_cycles, 5);
        chk("sat_cnt3", 32'(b3.stall_cycles), 7);

        // Branch beats load-use
        step(); load_use_a(); ex_BranchTaken = 1'b1; #1;
        chk("br_flush", b1.IF_ID_Flush, 1);
        chk("br_bub", b1.ID_EX_Bubble, 1);
        chk("br_pcw", b1.PCWrite, 1);
        chk("br_pcw3", b3.PCWrite, 1);
        step(); idle_in(); #1;
        chk("br_after3", b3.PCWrite, 1);
        chk("br_cnt1", b1.stall_cycles, 5);

        // Reset in second LOAD_STALL cycle, then clear vs increment
        step(); load_use_a();
        step(); idle_in();
        step(); rst_n = 1'b0; #1;
        chk("mrst_pcw3", b3.PCWrite, 1);
        chk("mrst_bub3", b3.ID_EX_Bubble, 0);
        chk("mrst_cnt3", 32'(b3.stall_cycles), 0);
        chk("mrst_cnt1", b1.stall_cycles, 0);
        step(); rst_n = 1'b1; load_use_a(); #1;
        chk("pc_lu_pcw", b1.PCWrite, 0);
        step(); #1;
        chk("pc_cnt1", b1.stall_cycles, 1);
        chk("pc_cnt3", 32'(b3.stall_cycles), 1);
        perf_clr = 1'b1; #1;
        chk("pc_pend1", b1.PCWrite, 0);
        step(); perf_clr = 1'b0; idle_in(); #1;
        chk("clr_cnt1", b1.stall_cycles, 0);
        chk("clr_cnt3", 32'(b3.stall_cycles), 0);
        chk("clr_pcw3", b3.PCWrite, 0);
        step(); #1;
        chk("clr_inc3", 32'(b3.stall_cycles), 1);
        chk("clr_rel3", b3.PCWrite, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
